// File: rtl/encoder_arbiter.sv
// Round-robin arbiter sharing one packet encoder among NUM_REQ requesters:
// grant -> descriptor handshake -> payload passthrough until tlast, with a starvation watchdog.

module encoder_arbiter_lane (
  input  logic        sel,
  input  logic        pass,
  input  logic        drain,
  input  logic        m_tready,
  input  logic [31:0] tdata,
  input  logic [3:0]  tstrb,
  input  logic        tlast,
  input  logic        tvalid,
  output logic        tready,
  output logic [31:0] mux_tdata,
  output logic [3:0]  mux_tstrb,
  output logic        mux_tlast,
  output logic        mux_tvalid
);
  // In DRAIN the granted lane is always ready so its remaining beats are discarded.
  assign tready     = sel & ((pass & m_tready) | drain);
  assign mux_tdata  = {32{sel}} & tdata;
  assign mux_tstrb  = {4{sel}} & tstrb;
  assign mux_tlast  = sel & tlast;
  assign mux_tvalid = sel & tvalid;
endmodule

module encoder_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int DESC_W         = 385,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DESC_W-1:0] req_desc,
  input  logic [NUM_REQ*32-1:0]     s_axis_tdata,
  input  logic [NUM_REQ*4-1:0]      s_axis_tstrb,
  input  logic [NUM_REQ-1:0]        s_axis_tlast,
  input  logic [NUM_REQ-1:0]        s_axis_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_tready,
  output logic [DESC_W-1:0]         enc_desc,
  output logic                      enc_valid,
  input  logic                      enc_ready,
  output logic                      enc_drop,
  output logic [31:0]               m_axis_tdata,
  output logic [3:0]                m_axis_tstrb,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [15:0]               abort_count
);
  localparam int  WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit  WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [WD_W-1:0] wd_cnt;
  logic [ID_W-1:0] pick;
  logic            found;
  logic            pass, drain;
  logic            beat, starved, abort;

  logic [NUM_REQ-1:0]       lane_sel;
  logic [NUM_REQ-1:0][31:0] lane_tdata;
  logic [NUM_REQ-1:0][3:0]  lane_tstrb;
  logic [NUM_REQ-1:0]       lane_tlast, lane_tvalid;
  logic [31:0]              sel_tdata;
  logic [3:0]               sel_tstrb;
  logic                     sel_tlast, sel_tvalid;

  assign pass  = (state == DATA);
  assign drain = (state == DRAIN);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_sel[i] = (grant_id == ID_W'(i));
    encoder_arbiter_lane u_lane (
      .sel        (lane_sel[i]),
      .pass       (pass),
      .drain      (drain),
      .m_tready   (m_axis_tready),
      .tdata      (s_axis_tdata[i*32 +: 32]),
      .tstrb      (s_axis_tstrb[i*4 +: 4]),
      .tlast      (s_axis_tlast[i]),
      .tvalid     (s_axis_tvalid[i]),
      .tready     (s_axis_tready[i]),
      .mux_tdata  (lane_tdata[i]),
      .mux_tstrb  (lane_tstrb[i]),
      .mux_tlast  (lane_tlast[i]),
      .mux_tvalid (lane_tvalid[i])
    );
  end

  // Lanes are zero unless selected, so an OR-reduce is the grant_id mux.
  always_comb begin
    sel_tdata = '0;
    sel_tstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_tdata = sel_tdata | lane_tdata[i];
      sel_tstrb = sel_tstrb | lane_tstrb[i];
    end
    sel_tlast  = |lane_tlast;
    sel_tvalid = |lane_tvalid;
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign beat    = pass & sel_tvalid & m_axis_tready;
  assign starved = pass & ~sel_tvalid;
  assign abort   = WD_EN & starved & (wd_cnt == WD_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = HDR;
      HDR:     if (enc_ready) state_nxt = DATA;
      DATA: begin
        if (beat && sel_tlast) state_nxt = IDLE;
        else if (abort)        state_nxt = DRAIN;
      end
      DRAIN:   if (sel_tvalid && sel_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      abort_count <= '0;
      enc_desc    <= '0;
      grant_id    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        enc_desc <= req_desc[int'(pick)*DESC_W +: DESC_W];
        grant_id <= pick;
        rr_ptr   <= (pick == ID_W'(NUM_REQ-1)) ? '0 : pick + ID_W'(1);
      end
      // Counter holds under encoder backpressure (tvalid & !tready).
      if (!pass || beat)  wd_cnt <= '0;
      else if (starved)   wd_cnt <= wd_cnt + WD_W'(1);
      if (abort && abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
    end
  end

  // req_ready is masked by reset so nothing is acknowledged while held in reset.
  assign req_ready     = (aresetn && state == IDLE && found) ? (NUM_REQ'(1) << pick) : '0;
  assign enc_valid     = (state == HDR);
  assign enc_drop      = abort;
  assign busy          = (state != IDLE);
  assign m_axis_tdata  = pass ? sel_tdata : '0;
  assign m_axis_tstrb  = pass ? sel_tstrb : '0;
  assign m_axis_tlast  = pass & sel_tlast;
  assign m_axis_tvalid = pass & sel_tvalid;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Directed bench for encoder_arbiter: NUM_REQ=4, TIMEOUT_CYCLES=16.
module tb_encoder_arbiter;
  localparam int N  = 4;
  localparam int DW = 385;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][DW-1:0] dsc;
  logic [N-1:0][31:0] td;
  logic [N-1:0][3:0]  ts;
  logic [N-1:0]      tl, tv;
  logic [N-1:0]      s_axis_tready;
  logic [DW-1:0]     enc_desc;
  logic              enc_valid, enc_ready, enc_drop;
  logic [31:0]       m_axis_tdata;
  logic [3:0]        m_axis_tstrb;
  logic              m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       abort_count;

  int passed = 0;
  int total  = 0;

  always #5 aclk = ~aclk;

  encoder_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_desc(dsc),
    .s_axis_tdata(td), .s_axis_tstrb(ts), .s_axis_tlast(tl),
    .s_axis_tvalid(tv), .s_axis_tready(s_axis_tready),
    .enc_desc(enc_desc), .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_drop(enc_drop),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant_id(grant_id), .busy(busy), .abort_count(abort_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_desc(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0; req_valid = '1; enc_ready = 1'b0; m_axis_tready = 1'b0;
    td = '0; ts = '0; tl = '0; tv = '0;
    for (int i = 0; i < N; i++) dsc[i] = {1'b1, {12{32'hD000_0000 | 32'(i)}}};
    step(); step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_enc_valid", enc_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_abort", abort_count, 0);
    chk_desc("rst_desc", enc_desc, '0);

    // round-robin with all requesters active, one-beat packets
    step();
    aresetn = 1'b1; enc_ready = 1'b1; m_axis_tready = 1'b1;
    tv = '1; tl = '1;
    for (int i = 0; i < N; i++) td[i] = 32'h100 + 32'(i);
    for (int p = 0; p < 6; p++) begin
      #1;
      chk("rr_req_ready", req_ready, 4'b0001 << (p % 4));
      step();
      chk("rr_grant", grant_id, p % 4);
      chk("rr_enc_valid", enc_valid, 1);
      step();
      chk("rr_tdata", m_axis_tdata, 32'h100 + 32'(p % 4));
      chk("rr_tready", s_axis_tready, 4'b0001 << (p % 4));
      if (p == 5) req_valid = '0;
      step();
    end
    tv = '0; tl = '0;

    // single requester 1, four beats
    req_valid = 4'b0010;
    #1;
    chk("t1_req_ready", req_ready, 4'b0010);
    chk("t1_busy_idle", busy, 0);
    step();
    req_valid = '0;
    chk("t1_enc_valid", enc_valid, 1);
    chk_desc("t1_desc", enc_desc, dsc[1]);
    chk("t1_req_ready_hdr", req_ready, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      tv[1] = 1'b1; td[1] = 32'hA0 + 32'(b); ts[1] = 4'(b + 1); tl[1] = (b == 3);
      #1;
      chk("t1_tvalid", m_axis_tvalid, 1);
      chk("t1_tdata", m_axis_tdata, 32'hA0 + 32'(b));
      chk("t1_tstrb", m_axis_tstrb, b + 1);
      chk("t1_tlast", m_axis_tlast, b == 3);
      chk("t1_tready", s_axis_tready, 4'b0010);
      step();
    end
    tv = '0; tl = '0;
    chk("t1_busy_end", busy, 0);

    // encoder stalls the header for 10 cycles (rr_ptr=2 wraps to 0)
    req_valid = 4'b0001; enc_ready = 1'b0;
    #1;
    chk("t3_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0; tv[0] = 1'b1; td[0] = 32'h30; tl[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t3_enc_valid", enc_valid, 1);
      chk_desc("t3_desc", enc_desc, dsc[0]);
      chk("t3_s_tready", s_axis_tready, 0);
      chk("t3_m_tvalid", m_axis_tvalid, 0);
      step();
    end
    enc_ready = 1'b1;
    step();
    chk("t3_data_tvalid", m_axis_tvalid, 1);
    chk("t3_data_tdata", m_axis_tdata, 32'h30);
    step();
    tv = '0; tl = '0;
    chk("t3_busy_end", busy, 0);

    // watchdog: requester 2 starves the encoder
    req_valid = 4'b0100;
    #1;
    chk("t4_req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    for (int k = 1; k <= 15; k++) begin
      chk("t4_no_drop", enc_drop, 0);
      step();
    end
    chk("t4_drop", enc_drop, 1);
    chk("t4_abort_before", abort_count, 0);
    step();
    chk("t4_drop_pulse", enc_drop, 0);
    chk("t4_abort", abort_count, 1);
    chk("t4_busy_drain", busy, 1);
    for (int b = 0; b < 3; b++) begin
      tv[2] = 1'b1; td[2] = 32'hB0 + 32'(b); tl[2] = (b == 2);
      #1;
      chk("t4_drain_tready", s_axis_tready, 4'b0100);
      chk("t4_drain_mvalid", m_axis_tvalid, 0);
      step();
    end
    tv = '0; tl = '0;
    chk("t4_busy_end", busy, 0);
    req_valid = 4'b0001;
    #1;
    chk("t4_next_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("t4_next_id", grant_id, 0);
    step();
    tv[0] = 1'b1; tl[0] = 1'b1; td[0] = 32'h40;
    step();
    tv = '0; tl = '0;

    // encoder backpressure on requester 3 never aborts
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    m_axis_tready = 1'b0; tv[3] = 1'b1; td[3] = 32'hC0; tl[3] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      chk("t5_stall_tready", s_axis_tready, 0);
      chk("t5_no_drop", enc_drop, 0);
      chk("t5_held_data", m_axis_tdata, 32'hC0);
      step();
    end
    m_axis_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      td[3] = 32'hC0 + 32'(b); tl[3] = (b == 2);
      #1;
      chk("t5_beat", m_axis_tdata, 32'hC0 + 32'(b));
      chk("t5_beat_tready", s_axis_tready, 4'b1000);
      step();
    end
    tv = '0; tl = '0;
    chk("t5_busy_end", busy, 0);
    chk("t5_abort_same", abort_count, 1);

    // reset mid-DATA; rr_ptr=0 so requester 1 is granted next
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    tv[1] = 1'b1; td[1] = 32'hE0; tl[1] = 1'b0;
    #1;
    chk("t6_pre_tvalid", m_axis_tvalid, 1);
    req_valid = 4'b0110;
    aresetn = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_enc_valid", enc_valid, 0);
    chk("t6_m_tvalid", m_axis_tvalid, 0);
    chk("t6_s_tready", s_axis_tready, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_abort", abort_count, 0);
    step();
    tv = '0;
    aresetn = 1'b1;
    #1;
    chk("t6_first_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    chk("t6_grant_id", grant_id, 1);
    chk_desc("t6_desc", enc_desc, dsc[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
